fetch_unit: RTL and testbench

Instruction-fetch front end for the MIPS core: it owns the program counter, issues word requests to instruction memory over a req/ack handshake, and hands fetched instructions to the decode/control stage with a valid/stall handshake. It absorbs redirects (taken beq/bne, j, jal, jr) computed downstream, discards wrong-path fetches, and stops on the halt word 32'hFFFF_FFFF. It sits between instruction memory and the control unit / register file read stage.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the MIPS core.
// Owns the PC, issues word fetches over a req/ack handshake, and holds one
// fetched instruction for decode under a valid/stall handshake. Downstream
// redirects replace the PC; a request still outstanding at that moment is
// finished in DISCARD and its data thrown away. The halt word stops fetching
// until a redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC4,
  output logic        IF_Halt
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;      // next address to fetch
  logic        r_pend;    // a request is outstanding (issued, not yet acked)
  logic [31:0] r_paddr;   // address of the outstanding request
  logic        r_run;     // low for the first cycle after reset release
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_halt;

  logic        w_free;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_take;
  logic [31:0] w_pc_next;
  logic [31:0] w_redir_pc;
  logic        w_is_halt;

  // Request/handshake decode. An outstanding request holds req and address
  // stable; a new one is only started in FETCH when the output slot is free.
  // Acks are taken only while the slot is free (in DISCARD it always is).
  always_comb begin
    w_free     = ~r_valid | ~Stall;
    w_req      = r_pend | (r_run & (r_state == S_FETCH) & w_free);
    w_addr     = r_pend ? r_paddr : r_pc;
    w_take     = w_req & imem_ack & w_free;
    w_pc_next  = w_addr + 32'd4;
    w_redir_pc = RedirectPC & 32'hFFFF_FFFC;
    w_is_halt  = (imem_rdata == HALT_WORD);
  end

  // Fetch state machine: PC, outstanding request, and the decode-facing slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_pend  <= 1'b0;
      r_paddr <= 32'h0000_0000;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= 32'h0000_0000;
      r_pc4   <= 32'h0000_0000;
      r_halt  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (Redirect) begin
        // Redirect wins over everything; an ack in this cycle is dropped.
        r_pc    <= w_redir_pc;
        r_valid <= 1'b0;
        r_halt  <= 1'b0;
        r_pend  <= w_req & ~w_take;
        r_paddr <= w_addr;
        r_state <= (w_req & ~w_take) ? S_DISCARD : S_FETCH;
      end else if (w_take) begin
        r_pend <= 1'b0;
        if (r_state == S_DISCARD) begin
          // Wrong-path data: drop it and resume at the redirected PC.
          r_state <= S_FETCH;
        end else begin
          r_instr <= imem_rdata;
          r_pc4   <= w_pc_next;
          r_valid <= 1'b1;
          r_pc    <= w_pc_next;
          if (w_is_halt) begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
      end else begin
        r_pend  <= w_req;
        r_paddr <= w_addr;
        if (r_valid & ~Stall) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= r_valid;
        end
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;
  assign IF_Valid  = r_valid;
  assign IF_Instr  = r_instr;
  assign IF_PC4    = r_pc4;
  assign IF_Halt   = r_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequences followed by randomized stall,
// redirect, memory-latency and reset stimulus, all checked cycle by cycle
// against a transaction-level model of the fetch front end.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLK;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC4;
  logic        IF_Halt;

  fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IF_Valid   (IF_Valid),
    .IF_Instr   (IF_Instr),
    .IF_PC4     (IF_PC4),
    .IF_Halt    (IF_Halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the front end has promised so far.
  logic [31:0] m_pc;       // where the next new fetch goes
  logic        m_idle;     // first cycle after reset release: no request yet
  logic        m_pend;     // memory transaction in flight
  logic [31:0] m_paddr;    // its address
  logic        m_wrong;    // in-flight transaction belongs to the old path
  logic        m_halted;   // halt word seen, fetching stopped
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_halt;

  // Memory responder state
  logic        mem_busy;
  int          mem_cnt;
  int          mem_lat;
  int          fixed_lat;
  logic        rand_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_0000: w = 32'h2009_0005;
      32'h0000_0004: w = 32'h2129_0001;
      32'h0000_0008: w = 32'h0000_0000;
      32'h0000_000C: w = 32'h0128_5020;
      32'h0000_0014: w = HALT;
      32'h0000_0030: w = 32'h1000_FFFF;
      default: begin
        if (a[7:2] == 6'h2B) w = HALT;
        else                 w = {a[15:0] ^ 16'hC3A5, ~a[15:0]};
      end
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_idle = 1'b1; m_pend = 1'b0; m_paddr = 32'h0; m_wrong = 1'b0;
    m_halted = 1'b0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_halt = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  // Enter at posedge+1. Asserts RST mid-cycle, checks the asynchronous
  // response, holds across an edge and releases.
  task automatic do_reset();
    Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; imem_ack = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr,         32'h0);
    check("rst_valid", {31'd0, IF_Valid}, 32'd0);
    check("rst_halt",  {31'd0, IF_Halt},  32'd0);
    check("rst_instr", IF_Instr,          32'h0);
    check("rst_pc4",   IF_PC4,            32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One clock cycle: enter at posedge+1, leave at the next posedge+1.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
    logic        e_req;
    logic [31:0] e_addr;
    logic        fr;
    logic        ak;
    logic        hs;
    Stall = st; Redirect = rd; RedirectPC = rpc;
    fr = !m_valid || !st;
    if (m_pend) begin
      e_req = 1'b1; e_addr = m_paddr;
    end else if (!m_idle && !m_halted && fr) begin
      e_req = 1'b1; e_addr = m_pc;
    end else begin
      e_req = 1'b0; e_addr = m_pc;
    end
    #1;
    check("req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check("addr", imem_addr, e_addr);
    // Memory: latency counted from the first request cycle; the ack is held
    // back while decode cannot take the word.
    if (imem_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_cnt  = 0;
      mem_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end
    ak = imem_req && mem_busy && (mem_cnt >= mem_lat) && fr;
    imem_ack   = ak;
    imem_rdata = ak ? mem_word(imem_addr) : $urandom;
    #1;
    check("valid", {31'd0, IF_Valid}, {31'd0, m_valid});
    check("halt",  {31'd0, IF_Halt},  {31'd0, m_halt});
    if (m_valid) begin
      check("instr", IF_Instr, m_instr);
      check("pc4",   IF_PC4,   m_pc4);
    end
    @(posedge CLK);
    hs = e_req && ak;
    m_idle = 1'b0;
    if (rd) begin
      m_pc     = {rpc[31:2], 2'b00};
      m_valid  = 1'b0;
      m_halt   = 1'b0;
      m_halted = 1'b0;
      m_pend   = e_req && !hs;
      m_paddr  = e_addr;
      m_wrong  = e_req && !hs;
    end else if (hs) begin
      m_pend = 1'b0;
      if (m_wrong) begin
        m_wrong = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_instr = mem_word(e_addr);
        m_pc4   = e_addr + 32'd4;
        m_pc    = e_addr + 32'd4;
        if (m_instr == HALT) begin
          m_halt   = 1'b1;
          m_halted = 1'b1;
        end
      end
    end else begin
      m_pend  = e_req;
      m_paddr = e_addr;
      if (m_valid && !st) m_valid = 1'b0;
    end
    if (ak)            mem_busy = 1'b0;
    else if (mem_busy) mem_cnt++;
    #1;
    imem_ack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    rand_lat = 1'b0; fixed_lat = 0; mem_lat = 0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Zero-wait stream 0,4,8,C
    cycle(1'b0, 1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    check("tp1_instr", IF_Instr, 32'h0128_5020);
    check("tp1_pc4",   IF_PC4,   32'h0000_0010);

    // Stall three cycles on 0x0128_5020, then resume at 0x10
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    check("stall_hold", IF_Instr, 32'h0128_5020);
    cycle(1'b0, 1'b0, 32'h0);
    check("resume_pc4", IF_PC4, 32'h0000_0014);

    // Redirect to 0x30 (drops the 0x14 ack), then redirect again in the
    // cycle 0x1000_FFFF is acked
    cycle(1'b0, 1'b1, 32'h0000_0030);
    cycle(1'b0, 1'b1, 32'h0000_0080);
    check("tp4_drop", {31'd0, IF_Valid}, 32'd0);

    // 2-cycle memory, redirect to 0x43 while 0x8 is outstanding
    cycle(1'b0, 1'b1, 32'h0000_0000);
    fixed_lat = 2;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0043);
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    check("tp3_valid", {31'd0, IF_Valid}, 32'd1);
    check("tp3_pc4",   IF_PC4, 32'h0000_0044);

    // Halt word at 0x14, stay stopped, then redirect to 0x20
    fixed_lat = 0;
    cycle(1'b0, 1'b1, 32'h0000_0014);
    cycle(1'b0, 1'b0, 32'h0);
    check("tp5_halt", {31'd0, IF_Halt}, 32'd1);
    repeat (12) cycle(1'b0, 1'b0, 32'h0);
    check("tp5_sticky", {31'd0, IF_Halt}, 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0020);
    check("tp5_clear", {31'd0, IF_Halt}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    check("tp5_resume", IF_PC4, 32'h0000_0024);

    // Wrap at the top of the address space, then reset mid 3-cycle request
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_pc4", IF_PC4, 32'h0000_0000);
    fixed_lat = 3;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    do_reset();

    // Randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0,
              $urandom_range(0, 11) == 0,
              ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'h0000_01FF));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
